// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART transmitter constants and arbiter state encoding
package uart_pkg;

   localparam logic [3:0] UART_BUSY_IDLE   = 4'd0;
   localparam int         UART_FRAME_BYTES = 16;
   localparam int         PAYLOAD_W        = UART_FRAME_BYTES * 8;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_LAUNCH,
      ARB_WAIT,
      ARB_DONE
   } arbState_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational one-hot requester selector, round-robin from pointer
// UART_ARB_FIXED_PRIO_EN selects the fixed-priority form (lowest index wins, pointer ignored).
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   pointer,
   output logic [NUM_REQ-1:0] winner,
   output logic [PTR_W-1:0]   winnerIdx,
   output logic               valid
);

   always_comb begin
      winner    = '0;
      winnerIdx = '0;
      valid     = 1'b0;
`ifdef UART_ARB_FIXED_PRIO_EN
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            winner    = '0;
            winner[i] = 1'b1;
            winnerIdx = PTR_W'(i);
            valid     = 1'b1;
         end
      end
`else
      // Scan upward from the pointer with wrap; the first requester found wins.
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!valid && req[(int'(pointer) + k) % NUM_REQ]) begin
            winner[(int'(pointer) + k) % NUM_REQ] = 1'b1;
            winnerIdx = PTR_W'((int'(pointer) + k) % NUM_REQ);
            valid     = 1'b1;
         end
      end
`endif
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one 128-bit-payload UART transmitter among NUM_REQ requesters
// UART_ARB_FIXED_PRIO_EN switches arbitration to fixed priority with the pointer held at 0.
module uart_tx_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int PAYLOAD_W     = uart_pkg::PAYLOAD_W,
   parameter int START_TIMEOUT = 16,
   parameter int CNT_W         = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*PAYLOAD_W-1:0] payload_in,
   output logic [NUM_REQ-1:0]           grant,
   output logic [NUM_REQ-1:0]           ack,
   output logic [PAYLOAD_W-1:0]         uart_payload,
   output logic                         uart_ready,
   input  logic [3:0]                   uart_busy,
   output logic                         err_timeout
);
   import uart_pkg::*;

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arbState_t          state, stateNext;
   logic [NUM_REQ-1:0] pickOneHot;
   logic [PTR_W-1:0]   pickIdx;
   logic               pickValid;
   logic [PTR_W-1:0]   ptr, winIdx, nextPtr;
   logic [CNT_W-1:0]   cnt;
   logic               busyIdle;
   logic               doGrant, launchSeen, launchTimeout, txDone;

   assign busyIdle = (uart_busy == UART_BUSY_IDLE);

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) uPick (
      .req       (req),
      .pointer   (ptr),
      .winner    (pickOneHot),
      .winnerIdx (pickIdx),
      .valid     (pickValid)
   );

`ifdef UART_ARB_FIXED_PRIO_EN
   assign nextPtr = '0;
`else
   assign nextPtr = (winIdx == PTR_W'(NUM_REQ - 1)) ? '0 : winIdx + PTR_W'(1);
`endif

   always_ff @(posedge clk) begin
      if (rst) state <= ARB_IDLE;
      else     state <= stateNext;
   end

   always_comb begin
      stateNext     = state;
      doGrant       = 1'b0;
      launchSeen    = 1'b0;
      launchTimeout = 1'b0;
      txDone        = 1'b0;
      unique case (state)
         // The transmitter has no reset, so a launch also waits for it to be idle.
         ARB_IDLE: if (pickValid && busyIdle) begin
            doGrant   = 1'b1;
            stateNext = ARB_LAUNCH;
         end
         ARB_LAUNCH: if (!busyIdle) begin
            launchSeen = 1'b1;
            stateNext  = ARB_WAIT;
         end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
            launchTimeout = 1'b1;
            stateNext     = ARB_DONE;
         end
         ARB_WAIT: if (busyIdle) begin
            txDone    = 1'b1;
            stateNext = ARB_DONE;
         end
         ARB_DONE: stateNext = ARB_IDLE;
         default:  stateNext = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant        <= '0;
         ack          <= '0;
         err_timeout  <= 1'b0;
         uart_ready   <= 1'b1;
         uart_payload <= '0;
         ptr          <= '0;
         winIdx       <= '0;
         cnt          <= '0;
      end else begin
         ack         <= '0;
         err_timeout <= 1'b0;
         if (doGrant) begin
            grant        <= pickOneHot;
            winIdx       <= pickIdx;
            uart_payload <= payload_in[int'(pickIdx)*PAYLOAD_W +: PAYLOAD_W];
            uart_ready   <= 1'b0;
            cnt          <= '0;
         end
         if (state == ARB_LAUNCH) cnt <= cnt + CNT_W'(1);
         if (launchSeen || launchTimeout) uart_ready <= 1'b1;
         if (launchTimeout) err_timeout <= 1'b1;
         // ack is visible during DONE, alongside the still-held grant.
         if (launchTimeout || txDone) ack <= grant;
         if (state == ARB_DONE) begin
            grant <= '0;
            ptr   <= nextPtr;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter with a frame-level model
// Expectations follow UART_ARB_FIXED_PRIO_EN when the bench is built with it.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ       = 4;
   localparam int PW            = 128;
   localparam int START_TIMEOUT = 16;

   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [NUM_REQ-1:0]      req = '0;
   logic [NUM_REQ*PW-1:0]   payload_in = '0;
   logic [3:0]              busy = 4'd0;
   logic [NUM_REQ-1:0]      grant, ack;
   logic [PW-1:0]           uart_payload;
   logic                    uart_ready, err_timeout;

   int checks = 0;
   int errors = 0;

   uart_tx_arbiter #(
      .NUM_REQ       (NUM_REQ),
      .PAYLOAD_W     (PW),
      .START_TIMEOUT (START_TIMEOUT),
      .CNT_W         (5)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .payload_in   (payload_in),
      .grant        (grant),
      .ack          (ack),
      .uart_payload (uart_payload),
      .uart_ready   (uart_ready),
      .uart_busy    (busy),
      .err_timeout  (err_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int idxOf(input logic [NUM_REQ-1:0] v);
      int r = -1;
      for (int i = 0; i < NUM_REQ; i++) if (v[i]) r = i;
      return r;
   endfunction

   // Winner = requested index closest to the pointer going upward (or lowest index when fixed).
   function automatic int pick(input logic [NUM_REQ-1:0] r, input int p);
      int best = -1;
      int bestD = NUM_REQ;
      int d;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r[i]) begin
`ifdef UART_ARB_FIXED_PRIO_EN
            d = i;
`else
            d = (i - p + NUM_REQ) % NUM_REQ;
`endif
            if (d < bestD) begin
               bestD = d;
               best  = i;
            end
         end
      end
      return best;
   endfunction

   // Frame-level model: phase 0 free, 1 waiting for transmitter start, 2 transmitting, 3 completing.
   logic [NUM_REQ-1:0] expGrant = '0, expAck = '0;
   logic               expReady = 1'b1, expErr = 1'b0;
   logic [PW-1:0]      expPayload = '0;
   int mPhase = 0, mWin = 0, mPtr = 0, mLow = 0;

   always @(posedge clk) begin
      if (rst) begin
         mPhase = 0; mPtr = 0; mLow = 0;
         expGrant = '0; expAck = '0; expErr = 1'b0; expReady = 1'b1; expPayload = '0;
      end else begin
         expAck = '0;
         expErr = 1'b0;
         case (mPhase)
            0: if (req != 0 && busy == 0) begin
               mWin       = pick(req, mPtr);
               expGrant   = '0;
               expGrant[mWin] = 1'b1;
               expPayload = payload_in[mWin*PW +: PW];
               expReady   = 1'b0;
               mLow       = 0;
               mPhase     = 1;
            end
            1: begin
               mLow++;
               if (busy != 0) begin
                  expReady = 1'b1;
                  mPhase   = 2;
               end else if (mLow == START_TIMEOUT) begin
                  expReady = 1'b1;
                  expErr   = 1'b1;
                  expAck   = expGrant;
                  mPhase   = 3;
               end
            end
            2: if (busy == 0) begin
               expAck = expGrant;
               mPhase = 3;
            end
            default: begin
               expGrant = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
               mPtr = 0;
`else
               mPtr = (mWin + 1) % NUM_REQ;
`endif
               mPhase = 0;
            end
         endcase
      end
   end

   int grantLog[$];
   logic [NUM_REQ-1:0] prevGrant = '0;
   int ackTotal = 0, errTotal = 0, errWithAck = 0, lowLen = 0, lastLow = 0, lastAckIdx = -1;
   logic [PW-1:0] payloadAtAck = '0;

   always @(negedge clk) begin
      chk("grant", grant, expGrant);
      chk("ack", ack, expAck);
      chk("uart_ready", uart_ready, expReady);
      chk("uart_payload", uart_payload, expPayload);
      chk("err_timeout", err_timeout, expErr);
      chk("grant_onehot0", $onehot0(grant), 1'b1);
      chk("ack_in_grant", ack & ~grant, '0);
      if (grant != 0 && prevGrant == 0) grantLog.push_back(idxOf(grant));
      prevGrant = grant;
      if (ack != 0) begin
         ackTotal++;
         lastAckIdx   = idxOf(ack);
         payloadAtAck = uart_payload;
      end
      if (err_timeout) begin
         errTotal++;
         if (ack != 0) errWithAck++;
      end
      if (!uart_ready) lowLen++;
      else if (lowLen != 0) begin
         lastLow = lowLen;
         lowLen  = 0;
      end
   end

   // Transmitter model and requesters, updated just after each falling edge.
   int  busyCnt = 0, txLen = 0;
   bit  txRespond = 0, holdReq = 0;

   task automatic tick();
      @(negedge clk);
      #1;
      if (busyCnt > 0) begin
         busyCnt--;
         if (busyCnt == 0) busy = 4'd0;
      end else if (txRespond && !uart_ready) begin
         busyCnt = txLen;
         busy    = 4'd2;
      end
      if (!holdReq) req = req & ~ack;
   endtask

   task automatic waitAcks(input int target, input int limit, input string name);
      int k = 0;
      while (ackTotal < target && k < limit) begin
         tick();
         k++;
      end
      chk(name, ackTotal >= target, 1'b1);
   endtask

   task automatic collectGrants(input int n, input int limit, input string name);
      int k = 0;
      while (grantLog.size() < n && k < limit) begin
         tick();
         k++;
      end
      chk(name, grantLog.size() >= n, 1'b1);
   endtask

   task automatic pulseReset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   int base, eBase, ewBase, prevBusy, waited, lastGrant;
   int expOrder[5];
   int expOrder6[4];
   logic [PW-1:0] payA, payB;

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      chk("reset_grant", grant, '0);
      chk("reset_ready", uart_ready, 1'b1);
      chk("reset_payload", uart_payload, '0);
      chk("reset_ack", ack, '0);

      // Single requester, long transmission.
      payA = 128'h00112233445566778899AABBCCDDEEFF;
      payload_in[0 +: PW] = payA;
      txRespond = 1; txLen = 100;
      grantLog.delete();
      base = ackTotal;
      req = 4'b0001;
      waitAcks(base + 1, 300, "t1_ack_arrives");
      lastGrant = (grantLog.size() > 0) ? grantLog[$] : -1;
      chk("t1_grant_count", grantLog.size(), 1);
      chk("t1_grant_idx", lastGrant, 0);
      chk("t1_ack_idx", lastAckIdx, 0);
      chk("t1_payload", payloadAtAck, payA);
      chk("t1_ready_low_cycles", lastLow, 1);
      repeat (3) tick();
      chk("t1_idle_grant", grant, '0);
      chk("t1_single_ack", ackTotal - base, 1);

      // All requesters held: rotation from pointer 0.
      pulseReset();
      grantLog.delete();
      base = ackTotal;
      txLen = 5; holdReq = 1; req = 4'b1111;
      collectGrants(5, 300, "t2_five_grants");
      holdReq = 0; req = '0;
      repeat (30) tick();
`ifdef UART_ARB_FIXED_PRIO_EN
      expOrder = '{0, 0, 0, 0, 0};
`else
      expOrder = '{0, 1, 2, 3, 0};
`endif
      for (int i = 0; i < 5; i++)
         chk($sformatf("t2_order_%0d", i), (grantLog.size() > i) ? grantLog[i] : -1, expOrder[i]);
      chk("t2_one_ack_per_frame", ackTotal - base, grantLog.size());

      // Transmitter never starts: launch times out.
      txRespond = 0;
      base = ackTotal; eBase = errTotal; ewBase = errWithAck;
      req = 4'b0100;
      waitAcks(base + 1, 100, "t3_timeout_ack");
      chk("t3_ack_idx", lastAckIdx, 2);
      chk("t3_ready_low_cycles", lastLow, 16);
      chk("t3_err_pulses", errTotal - eBase, 1);
      chk("t3_err_with_ack", errWithAck - ewBase, 1);
      tick();
      // Pointer now past requester 2, so 0 outranks 1.
      txRespond = 1; txLen = 4;
      base = ackTotal;
      req = 4'b0011;
      waitAcks(base + 1, 100, "t3_next_ack");
      chk("t3_ptr_advanced", lastAckIdx, 0);
      waitAcks(base + 2, 100, "t3_second_ack");
      chk("t3_second_idx", lastAckIdx, 1);

      // Payload changes after grant do not reach the frame in flight.
      payA = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
      payB = 128'h55555555_AAAAAAAA_55555555_AAAAAAAA;
      payload_in[0 +: PW] = payA;
      txLen = 20; base = ackTotal;
      req = 4'b0001;
      waited = 0;
      while (!(grant[0] && uart_ready) && waited < 50) begin
         tick();
         waited++;
      end
      chk("t4_reached_wait", grant[0] && uart_ready, 1'b1);
      payload_in[0 +: PW] = payB;
      waitAcks(base + 1, 100, "t4_ack");
      chk("t4_payload_at_ack", payloadAtAck, payA);
      chk("t4_payload_held", uart_payload, payA);

      // Reset during WAIT while the transmitter stays busy.
      payload_in[1*PW +: PW] = payB;
      txLen = 60;
      req = 4'b0010;
      waited = 0;
      while (!(grant[1] && uart_ready && busy != 0) && waited < 50) begin
         tick();
         waited++;
      end
      chk("t5_reached_wait", grant[1] && uart_ready && busy != 0, 1'b1);
      pulseReset();
      chk("t5_reset_grant", grant, '0);
      chk("t5_reset_ready", uart_ready, 1'b1);
      chk("t5_reset_payload", uart_payload, '0);
      waited = 0;
      prevBusy = busy;
      while (grant == 0 && waited < 100) begin
         prevBusy = busy;
         tick();
         waited++;
      end
      chk("t5_busy_at_grant", prevBusy, 0);
      chk("t5_grant_after_busy", grant, 4'b0010);
      chk("t5_blocked_while_busy", waited > 20, 1'b1);
      base = ackTotal;
      waitAcks(base + 1, 200, "t5_ack");

      // Requesters 0, 1 and 3 held.
      pulseReset();
      grantLog.delete();
      txLen = 3; holdReq = 1; req = 4'b1011;
      collectGrants(4, 200, "t6_four_grants");
      holdReq = 0; req = '0;
      repeat (20) tick();
`ifdef UART_ARB_FIXED_PRIO_EN
      expOrder6 = '{0, 0, 0, 0};
`else
      expOrder6 = '{0, 1, 3, 0};
`endif
      for (int i = 0; i < 4; i++)
         chk($sformatf("t6_order_%0d", i), (grantLog.size() > i) ? grantLog[i] : -1, expOrder6[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
